// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32I core: generic Zicsr read/write port
// plus dedicated trap-logic access to mtvec, mepc and mcause.
module csr_file #(
  parameter logic [31:0] MISA_VALUE = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [11:0] a,
  input  logic [31:0] di,
  output logic [31:0] csrDo,
  output logic [31:0] mepcDo,
  output logic [31:0] mtvecDo,
  output logic [31:0] mcauseDo,
  input  logic        mepcWe,
  input  logic [31:0] mepcDi,
  input  logic        mcauseWe,
  input  logic [31:0] mcauseDi
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned ALEN = 12;

  localparam logic [ALEN-1:0] ADDR_MISA      = 12'h301;
  localparam logic [ALEN-1:0] ADDR_MTVEC     = 12'h305;
  localparam logic [ALEN-1:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [ALEN-1:0] ADDR_MEPC      = 12'h341;
  localparam logic [ALEN-1:0] ADDR_MCAUSE    = 12'h342;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;

  logic [XLEN-1:0] mepcTrap;
  logic [XLEN-1:0] mepcGeneric;
  logic            mtvecModeLegal;

  // mepc is always word aligned; MODE values 2 and 3 are reserved.
  assign mepcTrap       = mepcDi & ALIGN_MASK;
  assign mepcGeneric    = di & ALIGN_MASK;
  assign mtvecModeLegal = ~di[1];

  // State update; reset dominates all write enables, trap writes beat generic writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mtvec    <= '0;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
    end else begin
      if (we && (a == ADDR_MTVEC) && mtvecModeLegal) begin
        mtvec <= di;
      end
      if (we && (a == ADDR_MSCRATCH)) begin
        mscratch <= di;
      end
      if (mepcWe) begin
        mepc <= mepcTrap;
      end else if (we && (a == ADDR_MEPC)) begin
        mepc <= mepcGeneric;
      end
      if (mcauseWe) begin
        mcause <= mcauseDi;
      end
    end
  end

  // Generic read mux; ID registers and unmapped addresses read zero.
  always_comb begin
    csrDo = '0;
    case (a)
      ADDR_MISA:     csrDo = MISA_VALUE;
      ADDR_MTVEC:    csrDo = mtvec;
      ADDR_MSCRATCH: csrDo = mscratch;
      ADDR_MEPC:     csrDo = mepc;
      ADDR_MCAUSE:   csrDo = mcause;
      default:       csrDo = '0;
    endcase
  end

  assign mepcDo   = mepc;
  assign mtvecDo  = mtvec;
  assign mcauseDo = mcause;

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file with hand-computed expectations.
module tb_csr_file;

  logic        clk;
  logic        reset;
  logic        we;
  logic [11:0] a;
  logic [31:0] di;
  logic [31:0] csrDo;
  logic [31:0] mepcDo;
  logic [31:0] mtvecDo;
  logic [31:0] mcauseDo;
  logic        mepcWe;
  logic [31:0] mepcDi;
  logic        mcauseWe;
  logic [31:0] mcauseDi;

  int errors = 0;
  int checks = 0;

  csr_file dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .a        (a),
    .di       (di),
    .csrDo    (csrDo),
    .mepcDo   (mepcDo),
    .mtvecDo  (mtvecDo),
    .mcauseDo (mcauseDo),
    .mepcWe   (mepcWe),
    .mepcDi   (mepcDi),
    .mcauseWe (mcauseWe),
    .mcauseDi (mcauseDi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    we       = 1'b0;
    a        = 12'h000;
    di       = '0;
    mepcWe   = 1'b0;
    mepcDi   = '0;
    mcauseWe = 1'b0;
    mcauseDi = '0;

    // Reset
    tick();
    check("rst_mtvec", mtvecDo, 32'h0);
    check("rst_mepc", mepcDo, 32'h0);
    check("rst_mcause", mcauseDo, 32'h0);
    a = 12'h301; #1;
    check("rst_misa", csrDo, 32'h4000_0100);
    a = 12'h305; #1;
    check("rst_rd_mtvec", csrDo, 32'h0);
    a = 12'h341; #1;
    check("rst_rd_mepc", csrDo, 32'h0);
    reset = 1'b1;

    // misa is read-only
    a = 12'h301; di = 32'd420; we = 1'b0;
    tick();
    check("misa_we0", csrDo, 32'h4000_0100);
    we = 1'b1;
    tick();
    check("misa_we1", csrDo, 32'h4000_0100);

    // mtvec WARL on MODE
    a = 12'h305; di = 32'hFC; we = 1'b0;
    tick();
    check("mtvec_we0", csrDo, 32'h0);
    we = 1'b1;
    tick();
    check("mtvec_fc", csrDo, 32'hFC);
    di = 32'hFF;
    tick();
    check("mtvec_ff_drop", csrDo, 32'hFC);
    di = 32'hFE;
    tick();
    check("mtvec_fe_drop", csrDo, 32'hFC);
    di = 32'hFD;
    tick();
    check("mtvec_fd", csrDo, 32'hFD);
    check("mtvecDo_fd", mtvecDo, 32'hFD);

    // mscratch and generic mepc
    a = 12'h340; we = 1'b0; di = 32'd45446848;
    tick();
    check("mscratch_we0", csrDo, 32'h0);
    we = 1'b1;
    tick();
    check("mscratch_wr", csrDo, 32'd45446848);
    a = 12'h341; di = 32'd86492168;
    tick();
    check("mepc_wr", csrDo, 32'd86492168);
    check("mepcDo_wr", mepcDo, 32'd86492168);
    di = 32'h103;
    tick();
    check("mepc_align", csrDo, 32'h100);

    // mcause: generic writes ignored, dedicated port only
    a = 12'h342; di = 32'd508943;
    tick();
    check("mcause_gen_ign", csrDo, 32'h0);
    check("mcauseDo_gen_ign", mcauseDo, 32'h0);
    we = 1'b0; mcauseWe = 1'b1; mcauseDi = 32'd986;
    tick();
    check("mcause_port", mcauseDo, 32'd986);
    check("mcause_rd", csrDo, 32'd986);
    mcauseWe = 1'b0; mcauseDi = 32'd20;
    tick();
    check("mcause_hold", mcauseDo, 32'd986);

    // mepc dedicated port and priority
    mepcWe = 1'b1; mepcDi = 32'd80;
    tick();
    check("mepc_port", mepcDo, 32'd80);
    mepcWe = 1'b0; mepcDi = 32'd0;
    tick();
    check("mepc_hold", mepcDo, 32'd80);
    mepcWe = 1'b1; mepcDi = 32'h200; we = 1'b1; a = 12'h341; di = 32'h300;
    tick();
    check("mepc_prio", mepcDo, 32'h200);
    mepcDi = 32'h207; we = 1'b0;
    tick();
    check("mepc_port_align", mepcDo, 32'h204);

    // Concurrent trap write and generic write to a different CSR
    mepcDi = 32'h400; mcauseWe = 1'b1; mcauseDi = 32'h8000_000B;
    we = 1'b1; a = 12'h340; di = 32'hCAFE_F00D;
    tick();
    check("conc_mepc", mepcDo, 32'h400);
    check("conc_mcause", mcauseDo, 32'h8000_000B);
    check("conc_mscratch", csrDo, 32'hCAFE_F00D);
    mepcWe = 1'b0; mcauseWe = 1'b0;

    // ID and unmapped addresses read zero and ignore writes
    for (int i = 0; i < 4; i++) begin
      a = 12'hF11 + 12'(i); di = 32'hFFFF_FFFF; we = 1'b1;
      tick();
      check("id_zero", csrDo, 32'h0);
    end
    a = 12'h7C0; di = 32'h1234_5678;
    tick();
    check("unmapped_zero", csrDo, 32'h0);
    we = 1'b0; a = 12'h340; #1;
    check("unmapped_no_side", csrDo, 32'hCAFE_F00D);
    check("unmapped_mtvec", mtvecDo, 32'hFD);

    // Reset overrides all writes
    reset = 1'b0; we = 1'b1; a = 12'h305; di = 32'hDEAD_BEEC;
    mepcWe = 1'b1; mepcDi = 32'h1000; mcauseWe = 1'b1; mcauseDi = 32'h5;
    tick();
    check("midrst_mtvec", mtvecDo, 32'h0);
    check("midrst_mepc", mepcDo, 32'h0);
    check("midrst_mcause", mcauseDo, 32'h0);
    a = 12'h340; #1;
    check("midrst_mscratch", csrDo, 32'h0);

    // First write after reset release is accepted
    reset = 1'b1; mepcWe = 1'b0; mcauseWe = 1'b0; di = 32'h1234;
    tick();
    check("post_rst_wr", csrDo, 32'h1234);
    we = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
